// File: rtl/pc_sequencer.sv
// Instruction fetch/PC sequencer: fetches a word per instruction over a simple
// req/ack memory port, decodes the next-PC source and updates the PC.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start after reset
// FETCH  | one-cycle setup, pc stable, timeout counter cleared
// WAIT   | imem_req high, waiting for imem_ack (bounded by MEM_TIMEOUT)
// DECODE | ir valid, pc_sel registered from ir[2:0]
// EXEC   | pc loads the selected next-PC
// HALT   | halted; start resumes at pc+1
// FAULT  | memory timeout or illegal state; terminal until reset
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] alu_out,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [1:0]  pc_sel,
    output logic        ir_valid,
    output logic [2:0]  state,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [1:0]  pc_sel_q, pc_sel_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        imem_req_q, imem_req_d;
    logic        ir_valid_q, ir_valid_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;

    logic [31:0] simm;
    logic [31:0] abs_tgt;

    assign simm    = {{16{ir_q[31]}}, ir_q[31:16]};
    assign abs_tgt = {16'h0000, ir_q[31:16]};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        pc_sel_d   = pc_sel_q;
        tmo_d      = tmo_q;
        ir_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                tmo_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An ack in the terminal timeout cycle still completes the fetch.
                if (imem_ack) begin
                    ir_d       = imem_rdata;
                    ir_valid_d = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_d == TMO_LIMIT) state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                case (ir_q[2:0])
                    3'b001:  pc_sel_d = branch_taken ? 2'd1 : 2'd0;
                    3'b010:  pc_sel_d = 2'd2;
                    3'b011:  pc_sel_d = 2'd3;
                    3'b111:  state_d  = S_HALT;
                    default: pc_sel_d = 2'd0;
                endcase
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (pc_sel_q)
                    2'd0:    pc_d = pc_q + 32'd1;
                    2'd1:    pc_d = pc_q + simm;
                    2'd2:    pc_d = alu_out;
                    default: pc_d = abs_tgt;
                endcase
            end
            S_HALT: begin
                if (start) begin
                    pc_d    = pc_q + 32'd1;
                    state_d = S_FETCH;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        // Status outputs are registered off the next state so they align with it.
        imem_req_d = (state_d == S_WAIT);
        halted_d   = (state_d == S_HALT);
        fault_d    = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 32'd0;
            pc_sel_q   <= 2'd0;
            tmo_q      <= 8'd0;
            imem_req_q <= 1'b0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            pc_sel_q   <= pc_sel_d;
            tmo_q      <= tmo_d;
            imem_req_q <= imem_req_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
        end
    end

    assign state    = state_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign pc_sel   = pc_sel_q;
    assign imem_req = imem_req_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver serves directed instruction words
// and queues expected ir / next-PC; a monitor checks them as the DUT presents them.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] alu_out = 32'd0;
    logic        branch_taken = 1'b0;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [1:0]  pc_sel;
    logic        ir_valid;
    logic [2:0]  state;
    logic        halted;
    logic        fault;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .alu_out(alu_out), .branch_taken(branch_taken),
        .imem_req(imem_req), .pc(pc), .ir(ir), .pc_sel(pc_sel),
        .ir_valid(ir_valid), .state(state), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  sel;
        bit          chk_sel;
        int          gap;
    } ret_t;

    ret_t        exp_ret[$];
    logic [31:0] exp_ir[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: ir on ir_valid, pc/pc_sel/period on every return to FETCH.
    logic [2:0] prev_state = 3'd0;
    int         last_ret = 0;
    always @(negedge clk) begin
        ret_t e;
        if (ir_valid) begin
            if (exp_ir.size() == 0) check("ir_unexpected", ir, 32'hxxxx_xxxx);
            else check("ir_load", ir, exp_ir.pop_front());
        end
        if (state == 3'd1 && (prev_state == 3'd4 || prev_state == 3'd5)) begin
            if (exp_ret.size() == 0) begin
                check("pc_unexpected_update", pc, 32'hxxxx_xxxx);
            end else begin
                e = exp_ret.pop_front();
                check("next_pc", pc, e.pc);
                if (e.chk_sel) check("pc_sel_hold", {30'd0, pc_sel}, {30'd0, e.sel});
                if (e.gap > 0) check("instr_period", cyc - last_ret, e.gap);
            end
            last_ret = cyc;
        end
        prev_state = state;
    end

    task automatic wait_req();
        int n = 0;
        while (!imem_req) begin
            @(negedge clk);
            n++;
            if (n > 40) begin
                $display("FAIL wait_imem_req: got timeout expected imem_req=1");
                $fatal(1, "imem_req never asserted");
            end
        end
    endtask

    // Serve one fetch: hold ack off for 'extra' WAIT cycles, then acknowledge.
    task automatic serve(input logic [31:0] word, input int extra, input logic bt,
                         input logic [31:0] alu, input logic [31:0] npc,
                         input logic [1:0] sel, input bit first);
        ret_t r;
        r.pc = npc; r.sel = sel; r.chk_sel = 1'b1;
        r.gap = first ? 0 : 4 + extra;
        exp_ir.push_back(word);
        exp_ret.push_back(r);
        wait_req();
        repeat (extra) @(negedge clk);
        imem_ack = 1'b1; imem_rdata = word; branch_taken = bt; alu_out = alu;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] word;
        int          extra;
        logic        bt;
        logic [31:0] alu;
        logic [31:0] npc;
        logic [1:0]  sel;
    } vec_t;

    vec_t vecs[12] = '{
        '{32'h0000_0000,  0, 1'b0, 32'h0,  32'h0000_0001, 2'd0},
        '{32'h0008_0003,  0, 1'b0, 32'h0,  32'h0000_0008, 2'd3},
        '{32'h0005_0001,  0, 1'b1, 32'h0,  32'h0000_000D, 2'd1},
        '{32'h0008_0003,  2, 1'b0, 32'h0,  32'h0000_0008, 2'd3},
        '{32'h0005_0001,  0, 1'b0, 32'h0,  32'h0000_0009, 2'd0},
        '{32'h0001_0003,  0, 1'b0, 32'h0,  32'h0000_0001, 2'd3},
        '{32'hFFFE_0001,  0, 1'b1, 32'h0,  32'hFFFF_FFFF, 2'd1},
        '{32'h0000_0000,  0, 1'b0, 32'h0,  32'h0000_0000, 2'd0},
        '{32'h0000_0002,  0, 1'b0, 32'h40, 32'h0000_0040, 2'd2},
        '{32'h1234_0003,  0, 1'b0, 32'h0,  32'h0000_1234, 2'd3},
        '{32'h0000_0004, 14, 1'b1, 32'h0,  32'h0000_1235, 2'd0},
        '{32'h0005_0003,  1, 1'b0, 32'h0,  32'h0000_0005, 2'd3}
    };

    initial begin
        ret_t r;
        #3;
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_outs", {27'd0, imem_req, ir_valid, halted, fault, pc_sel != 2'd0}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", {29'd0, state}, 32'd0);
        check("idle_no_req", {31'd0, imem_req}, 32'd0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (vecs[i])
            serve(vecs[i].word, vecs[i].extra, vecs[i].bt, vecs[i].alu,
                  vecs[i].npc, vecs[i].sel, i == 0);

        // HALT at pc 5, then resume
        exp_ir.push_back(32'h0000_0007);
        wait_req();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0007;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("halt_state", {29'd0, state}, 32'd5);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_pc", pc, 32'd5);
        r.pc = 32'd6; r.sel = 2'd0; r.chk_sel = 1'b0; r.gap = 0;
        exp_ret.push_back(r);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("resume_halted_clr", {31'd0, halted}, 32'd0);

        // Reset mid-WAIT takes effect without a clock edge
        wait_req();
        check("resume_req", {31'd0, imem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_pc", pc, 32'd0);
        check("async_rst_state", {29'd0, state}, 32'd0);
        check("async_rst_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("stale_ack_state", {29'd0, state}, 32'd0);
        check("stale_ack_ir", ir, 32'd0);
        imem_ack = 1'b0;

        // Memory timeout: 14 silent WAIT cycles still waiting, the 15th faults
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_req();
        repeat (14) @(negedge clk);
        check("tmo_14_wait", {29'd0, state}, 32'd2);
        @(negedge clk);
        check("tmo_state", {29'd0, state}, 32'd6);
        check("tmo_fault", {31'd0, fault}, 32'd1);
        check("tmo_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1; start = 1'b1; imem_rdata = 32'h0000_0003;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0; start = 1'b0;
        check("fault_sticky", {29'd0, state}, 32'd6);
        check("fault_pc_frozen", pc, 32'd0);
        check("fault_ir_frozen", ir, 32'd0);

        check("sb_ret_drained", exp_ret.size(), 32'd0);
        check("sb_ir_drained", exp_ir.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'd0: PC value loaded on reset.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 15: maximum WAIT cycles without imem_ack before a fault (range 1..255).
REQ-003 Port clk: input, 1 bit; single clock; all state updates on its rising edge.
REQ-004 Port rst: input, 1 bit; asynchronous, active-low reset.
REQ-005 Port start: input, 1 bit; leaves IDLE, or resumes from HALT.
REQ-006 Port imem_ack: input, 1 bit; instruction memory returns data this cycle.
REQ-007 Port imem_rdata: input, 32 bits; instruction word, valid when imem_ack=1.
REQ-008 Port alu_out: input, 32 bits; JAL target.
REQ-009 Port branch_taken: input, 1 bit; branch condition, sampled in DECODE.
REQ-010 Port imem_req: output, 1 bit; fetch request.
REQ-011 Port pc: output, 32 bits; current PC and fetch address.
REQ-012 Port ir: output, 32 bits; latched instruction.
REQ-013 Port pc_sel: output, 2 bits; next-PC source: 0 = pc+1, 1 = pc+simm, 2 = alu_out, 3 = absolute.
REQ-014 Port ir_valid: output, 1 bit; one-cycle pulse when ir is loaded.
REQ-015 Port state: output, 3 bits; FSM state encoding.
REQ-016 Port halted: output, 1 bit; high while in HALT.
REQ-017 Port fault: output, 1 bit; high while in FAULT.

Function
REQ-018 The FSM SHALL use states IDLE=0, FETCH=1, WAIT=2, DECODE=3, EXEC=4, HALT=5, FAULT=6; code 7 is illegal and SHALL go to FAULT.
REQ-019 IDLE SHALL go to FETCH when start=1, and otherwise stay in IDLE.
REQ-020 FETCH SHALL last exactly one cycle with pc stable and imem_req=0, then go to WAIT and clear the timeout counter.
REQ-021 In WAIT, imem_req SHALL be 1; when imem_ack=1, ir SHALL load imem_rdata and the FSM SHALL go to DECODE.
REQ-022 imem_ack SHALL be ignored in every state except WAIT.
REQ-023 The timeout counter SHALL increment on each WAIT cycle with imem_ack=0.
REQ-024 When the timeout counter reaches MEM_TIMEOUT, the FSM SHALL go to FAULT; if imem_ack=1 in that same cycle, the acknowledge wins.
REQ-025 ir_valid SHALL be 1 for exactly the first DECODE cycle after a load.
REQ-026 DECODE SHALL register pc_sel from ir[2:0] as follows:
  - 000, 100, 101, 110: pc_sel 0.
  - 001: pc_sel 1 if branch_taken=1, else 0.
  - 010: pc_sel 2.
  - 011: pc_sel 3.
  - 111: HALT.
REQ-027 pc_sel SHALL hold its value from DECODE through EXEC.
REQ-028 simm SHALL be ir[31:16] sign-extended to 32 bits; the absolute target SHALL be ir[31:16] zero-extended.
REQ-029 In EXEC, pc SHALL load the selected next-PC and the FSM SHALL go to FETCH; all additions SHALL be modulo 2^32 (0xFFFFFFFF+1 gives 0; negative simm wraps).
REQ-030 alu_out SHALL be sampled in EXEC.
REQ-031 On HALT decode, pc SHALL remain unchanged and halted SHALL be 1.
REQ-032 start=1 in HALT SHALL set pc to pc+1 and go to FETCH.
REQ-033 FAULT SHALL be terminal until reset: imem_req=0, pc and ir frozen.
REQ-034 Minimum instruction period SHALL be 4 cycles (FETCH, WAIT with ack, DECODE, EXEC); each extra WAIT cycle adds 1.
REQ-035 start SHALL be ignored in every state except IDLE and HALT.

Reset
REQ-036 rst=0 SHALL immediately, without waiting for a clock edge, set: state IDLE, pc RESET_PC, ir 0, pc_sel 0, imem_req 0, ir_valid 0, halted 0, fault 0, timeout counter 0.
REQ-037 Reset asserted mid-fetch (WAIT) SHALL drop imem_req in the same cycle, and a pending imem_ack after release SHALL be ignored.
REQ-038 After rst is deasserted, the block SHALL stay in IDLE until start=1.

Verification
REQ-039 The bench SHALL drive reset, then start, then fetch 0x00000000 with ack in the first WAIT cycle -> pc 0 then 1, with 4 cycles between pc updates.
REQ-040 The bench SHALL drive ir=0x0005_0001 at pc=8 with branch_taken=1 -> pc=13; the same with branch_taken=0 -> pc=9.
REQ-041 The bench SHALL drive ir=0xFFFE_0001 (simm=-2) at pc=1 with branch_taken=1 -> pc=0xFFFFFFFF; a following SEQ -> pc=0.
REQ-042 The bench SHALL drive JAL (ir=0x2) with alu_out=0x40 -> pc=0x40; ABS (ir=0x1234_0003) -> pc=0x1234.
REQ-043 The bench SHALL withhold imem_ack for 15 WAIT cycles -> fault=1, state=6, imem_req=0; ack arriving in cycle 15 -> normal DECODE.
REQ-044 The bench SHALL drive HALT (ir=0x7) at pc=5 -> halted=1, pc=5; then start -> pc=6 and fetch resumes; then rst pulsed low during WAIT -> pc=RESET_PC and state=IDLE immediately.
